shift_seq_ctrl: RTL and testbench

Iterative shift controller for the execute stage. It accepts one shift request at a time (SLL, SRL or SRA on a 64-bit operand with a 6-bit shift amount) over a valid/ready handshake. It drives a narrow per-cycle shifter, moving the operand at most STEP bits per clock, and returns the result over a second valid/ready handshake. It replaces a full-width barrel shifter where area matters, and the ALU issue logic sequences all shift instructions through it.

---
 rtl/shift_seq_ctrl.sv | 103 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: iterative shifter for the execute stage.
// A request (SLL/SRL/SRA) is taken in IDLE. The operand then moves at most
// STEP bits per clock in SHIFT. The result is offered in DONE until it is consumed.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload steady
// until that edge. in_ready is decoded from the state register, rst and flush
// only. out_valid/out_result come from registers only.
module shift_seq_ctrl #(
    parameter int XLEN = 64,
    parameter int STEP = 8,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [SHW-1:0]  in_shamt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One bit wider than the shift amount so STEP == XLEN is still representable.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_rem;
    logic [1:0]      r_op;
    logic [SHW:0]    w_step;
    logic [SHW-1:0]  w_rem_next;
    logic [XLEN-1:0] w_acc_shifted;
    logic            w_accept;

    assign in_ready   = (r_state == S_IDLE) && !rst && !flush;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_DONE);
    assign out_result = out_valid ? r_acc : '0;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

    // Per-cycle step: min(rem, STEP), then the narrow shift of the accumulator.
    always_comb begin
        w_step        = ({1'b0, r_rem} < STEP_W) ? {1'b0, r_rem} : STEP_W;
        w_rem_next    = r_rem - w_step[SHW-1:0];
        w_acc_shifted = r_acc >> w_step;
        case (r_op)
            2'b00:   w_acc_shifted = r_acc << w_step;
            2'b11:   w_acc_shifted = XLEN'($signed(r_acc) >>> w_step);
            default: w_acc_shifted = r_acc >> w_step;
        endcase
    end

    // Next-state decode; flush overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_SHIFT;
            S_SHIFT: if (w_rem_next == '0) w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (flush) w_next_state = S_IDLE;
    end

    // State register; rst takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Datapath: capture on accept, step in SHIFT, hold in DONE, clear on abort.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_acc <= '0;
            r_rem <= '0;
            r_op  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_acc <= in_a;
                r_rem <= in_shamt;
                r_op  <= in_op;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_acc_shifted;
            r_rem <= w_rem_next;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed cases, then random requests checked
// against a reference computed directly from the shift rules.
module tb_shift_seq_ctrl;

    localparam int XLEN = 64;
    localparam int STEP = 8;
    localparam int SHW  = 6;

    // ---------------- clock / reset ----------------
    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [SHW-1:0]  in_shamt;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;
    logic [1:0]      dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    shift_seq_ctrl #(.XLEN(XLEN), .STEP(STEP), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_shamt(in_shamt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [XLEN-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_k    = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the whole shift in one step, plus the cycle count rule.
    function automatic logic [XLEN-1:0] ref_shift(input logic [1:0] op, input logic [XLEN-1:0] a, input int sh);
        logic signed [XLEN-1:0] sa;
        sa = a;
        case (op)
            2'b00:   return a << sh;
            2'b11:   return sa >>> sh;
            default: return a >> sh;
        endcase
    endfunction

    function automatic int ref_k(input int sh);
        return (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    endfunction

    // ---------------- driver tasks ----------------
    // Cycle 0: present the request, confirm it is acceptable.
    task automatic accept(input logic [1:0] op, input logic [XLEN-1:0] a, input int sh);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_shamt = SHW'(sh);
        #1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        exp_q.push_back(ref_shift(op, a, sh));
        exp_k = ref_k(sh);
    endtask

    // Walk through SHIFT; leaves the bench sampling the first DONE cycle.
    task automatic wait_done();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            cyc++;
            #1;
            if (cyc == 1) check("busy_c1", 64'(busy), 64'd1);
            if (!out_valid) check("in_ready_shift", 64'(in_ready), 64'd0);
        end while (!out_valid && cyc < 80);
        check("latency", 64'(cyc), 64'(exp_k + 1));
    endtask

    // Hold out_ready low for 'hold' cycles (poking in_valid), then consume.
    task automatic consume(input int hold);
        logic [XLEN-1:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", out_result, exp);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            in_a     = 64'hDEAD_BEEF_0000_0001;
            @(negedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("done_valid", 64'(out_valid), 64'd1);
        check("result", out_result, exp);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_req(input logic [1:0] op, input logic [XLEN-1:0] a, input int sh, input int hold);
        accept(op, a, sh);
        wait_done();
        consume(hold);
    endtask

    // ---------------- test sequence ----------------
    localparam logic [XLEN-1:0] PAT = 64'hF0F0_F0F0_F0F0_F0F0;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_a = '0; in_shamt = '0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // directed cases
        run_req(2'b01, PAT, 1, 0);
        run_req(2'b00, PAT, 32, 0);
        run_req(2'b01, PAT, 8, 0);
        run_req(2'b11, PAT, 63, 0);
        run_req(2'b11, 64'h70F0_F0F0_F0F0_F0F0, 4, 0);
        run_req(2'b01, PAT, 0, 3);

        // flush in the 3rd SHIFT cycle of SLL by 40
        accept(2'b00, PAT, 40);
        void'(exp_q.pop_back());
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready_after", 64'(in_ready), 64'd1);
        for (int c = 0; c < 6; c++) begin
            check("flush_no_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            #1;
        end

        // a request alongside flush in IDLE is not taken
        in_valid = 1'b1; in_op = 2'b01; in_a = PAT; in_shamt = 6'd4; flush = 1'b1;
        #1;
        check("flush_idle_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_idle_not_taken", 64'(busy), 64'd0);

        run_req(2'b01, PAT, 16, 0);

        // reset while in DONE
        accept(2'b00, PAT, 12);
        void'(exp_q.pop_back());
        wait_done();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_done_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1;
        check("rst_done_valid", 64'(out_valid), 64'd0);
        check("rst_done_result", out_result, 64'd0);
        check("rst_done_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_done_in_ready_after", 64'(in_ready), 64'd1);

        run_req(2'b10, PAT, 4, 0);

        // random requests
        for (int n = 0; n < 40; n++) begin
            run_req(2'($urandom_range(0, 3)), {$urandom, $urandom},
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
